// File: rtl/hls_layer_stream_adapter.sv
// Valid/ready wrapper around an externally instantiated HLS layer (fixed-latency or ap_done driven).
// Results land in a credit-managed FWFT FIFO so a start is only issued when its result has a slot.
module hls_layer_stream_adapter #(
    parameter int NUM_IN           = 1,
    parameter int IN_W             = 16,
    parameter int NUM_OUT          = 2,
    parameter int OUT_W            = 33,
    parameter int LATENCY          = 1,
    parameter int II               = 1,
    parameter int FIFO_DEPTH       = 4,
    parameter int POST_OUTPUT_WAIT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             data_in_valid,
    input  logic [NUM_IN*IN_W-1:0]           data_in,
    output logic                             data_in_ready,
    output logic                             data_out_valid,
    output logic [NUM_OUT*OUT_W-1:0]         data_out,
    input  logic                             data_out_ready,
    output logic                             layer_ap_rst,
    output logic                             layer_ap_start,
    output logic [NUM_IN*IN_W-1:0]           layer_data_in,
    input  logic [NUM_OUT*OUT_W-1:0]         layer_data_out,
    input  logic                             layer_ap_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             err_overflow
);

    localparam int DW_OUT = NUM_OUT * OUT_W;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);
    localparam int CW1    = CW + 1;
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam bit SEQ    = (LATENCY < 0);

    logic [DW_OUT-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     in_flight;

    logic in_fire;
    logic out_fire;
    logic capture;
    logic ii_ok;
    logic waiting;
    logic credit_ok;
    logic full;
    logic push;
    logic drop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on registered state and rst, never on data_out_ready.
    always_comb begin
        layer_ap_rst   = rst;
        layer_data_in  = data_in;
        credit_ok      = ({1'b0, in_flight} + {1'b0, count}) < CW1'(FIFO_DEPTH);
        data_in_ready  = ~rst & credit_ok & ii_ok & ~waiting & (~SEQ | (in_flight == '0));
        in_fire        = data_in_valid & data_in_ready;
        layer_ap_start = in_fire;
        data_out_valid = ~rst & (count != '0);
        out_fire       = data_out_valid & data_out_ready;
        data_out       = mem[rd_ptr];
        fifo_count     = rst ? '0 : count;
    end

    always_comb begin
        full = (count == CW'(FIFO_DEPTH));
        push = capture & (~full | out_fire);
        drop = capture & full & ~out_fire;
    end

    // Result capture strobe: delayed start for fixed latency, ap_done otherwise.
    if (LATENCY > 0) begin : g_fixed
        logic [LATENCY-1:0] lat_sr;
        logic               unused_done;

        always_ff @(posedge clk) begin
            if (rst) begin
                lat_sr <= '0;
            end else begin
                lat_sr <= (lat_sr << 1) | LATENCY'(in_fire);
            end
        end

        always_comb begin
            capture     = lat_sr[LATENCY-1];
            unused_done = layer_ap_done;
        end
    end else if (LATENCY == 0) begin : g_zero
        logic unused_done;

        always_comb begin
            capture     = in_fire;
            unused_done = layer_ap_done;
        end
    end else begin : g_seq
        always_comb begin
            capture = layer_ap_done & (in_flight == CW'(1));
        end
    end

    if (!SEQ && II > 1) begin : g_ii
        localparam int IIW = $clog2(II);
        logic [IIW-1:0] ii_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                ii_cnt <= '0;
            end else if (in_fire) begin
                ii_cnt <= IIW'(II - 1);
            end else if (ii_cnt != '0) begin
                ii_cnt <= ii_cnt - 1'b1;
            end
        end

        always_comb ii_ok = (ii_cnt == '0);
    end else begin : g_no_ii
        always_comb ii_ok = 1'b1;
    end

    if (POST_OUTPUT_WAIT > 0) begin : g_wait
        localparam int WW = $clog2(POST_OUTPUT_WAIT + 1);
        logic [WW-1:0] wait_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                wait_cnt <= '0;
            end else if (out_fire) begin
                wait_cnt <= WW'(POST_OUTPUT_WAIT);
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end

        always_comb waiting = (wait_cnt != '0);
    end else begin : g_no_wait
        always_comb waiting = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            in_flight    <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (out_fire) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, out_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({in_fire, capture})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: ;
            endcase
            if (drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; data_out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= layer_data_out;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !drop);
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, in_flight} + {1'b0, count}) <= CW1'(FIFO_DEPTH));
    a_seq_single: assert property (@(posedge clk) disable iff (rst)
        !SEQ || (in_flight <= CW'(1)));

endmodule

// File: tb/tb_hls_layer_stream_adapter.sv
// Directed bench: six adapter instances, one per configuration, share clk/rst/data_in/data_out_ready.
// The layer is modelled as a delay line of data_in feeding a fixed result function.
module tb_hls_layer_stream_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        out_rdy;
    logic        seq_done;
    logic [15:0] din;
    logic [15:0] seq_held;
    logic [15:0] hist [4];

    int checks = 0;
    int passed = 0;

    function automatic logic [65:0] f(input logic [15:0] x);
        return {33'h1_0000_0000 | {17'd0, x}, {17'd0, x} * 33'd3};
    endfunction

    always @(posedge clk) begin
        hist[0] <= din;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
    end

    logic [65:0] lo0, lo2, lo3, lo4, los;
    assign lo0 = f(din);
    assign lo2 = f(hist[1]);
    assign lo3 = f(hist[2]);
    assign lo4 = f(hist[3]);
    assign los = f(seq_held);

    logic s_v, s_rdy, s_ov, s_st, s_arst, s_err; logic [15:0] s_ldi; logic [65:0] s_od; logic [2:0] s_fc;
    logic b_v, b_rdy, b_ov, b_st, b_arst, b_err; logic [15:0] b_ldi; logic [65:0] b_od; logic [2:0] b_fc;
    logic i_v, i_rdy, i_ov, i_st, i_arst, i_err; logic [15:0] i_ldi; logic [65:0] i_od; logic [2:0] i_fc;
    logic q_v, q_rdy, q_ov, q_st, q_arst, q_err; logic [15:0] q_ldi; logic [65:0] q_od; logic [2:0] q_fc;
    logic p_v, p_rdy, p_ov, p_st, p_arst, p_err; logic [15:0] p_ldi; logic [65:0] p_od; logic [2:0] p_fc;
    logic r_v, r_rdy, r_ov, r_st, r_arst, r_err; logic [15:0] r_ldi; logic [65:0] r_od; logic [2:0] r_fc;

    always @(posedge clk) if (q_st) seq_held <= din;

    hls_layer_stream_adapter #(.NUM_IN(1), .IN_W(16), .NUM_OUT(2), .OUT_W(33), .LATENCY(3), .II(1),
        .FIFO_DEPTH(5), .POST_OUTPUT_WAIT(0)) u_str (
        .clk(clk), .rst(rst), .data_in_valid(s_v), .data_in(din), .data_in_ready(s_rdy),
        .data_out_valid(s_ov), .data_out(s_od), .data_out_ready(out_rdy), .layer_ap_rst(s_arst),
        .layer_ap_start(s_st), .layer_data_in(s_ldi), .layer_data_out(lo3), .layer_ap_done(1'b0),
        .fifo_count(s_fc), .err_overflow(s_err));

    hls_layer_stream_adapter #(.NUM_IN(1), .IN_W(16), .NUM_OUT(2), .OUT_W(33), .LATENCY(3), .II(1),
        .FIFO_DEPTH(4), .POST_OUTPUT_WAIT(0)) u_bp (
        .clk(clk), .rst(rst), .data_in_valid(b_v), .data_in(din), .data_in_ready(b_rdy),
        .data_out_valid(b_ov), .data_out(b_od), .data_out_ready(out_rdy), .layer_ap_rst(b_arst),
        .layer_ap_start(b_st), .layer_data_in(b_ldi), .layer_data_out(lo3), .layer_ap_done(1'b0),
        .fifo_count(b_fc), .err_overflow(b_err));

    hls_layer_stream_adapter #(.NUM_IN(1), .IN_W(16), .NUM_OUT(2), .OUT_W(33), .LATENCY(2), .II(3),
        .FIFO_DEPTH(4), .POST_OUTPUT_WAIT(0)) u_ii (
        .clk(clk), .rst(rst), .data_in_valid(i_v), .data_in(din), .data_in_ready(i_rdy),
        .data_out_valid(i_ov), .data_out(i_od), .data_out_ready(out_rdy), .layer_ap_rst(i_arst),
        .layer_ap_start(i_st), .layer_data_in(i_ldi), .layer_data_out(lo2), .layer_ap_done(1'b0),
        .fifo_count(i_fc), .err_overflow(i_err));

    hls_layer_stream_adapter #(.NUM_IN(1), .IN_W(16), .NUM_OUT(2), .OUT_W(33), .LATENCY(-1), .II(1),
        .FIFO_DEPTH(4), .POST_OUTPUT_WAIT(0)) u_seq (
        .clk(clk), .rst(rst), .data_in_valid(q_v), .data_in(din), .data_in_ready(q_rdy),
        .data_out_valid(q_ov), .data_out(q_od), .data_out_ready(out_rdy), .layer_ap_rst(q_arst),
        .layer_ap_start(q_st), .layer_data_in(q_ldi), .layer_data_out(los), .layer_ap_done(seq_done),
        .fifo_count(q_fc), .err_overflow(q_err));

    hls_layer_stream_adapter #(.NUM_IN(1), .IN_W(16), .NUM_OUT(2), .OUT_W(33), .LATENCY(0), .II(1),
        .FIFO_DEPTH(4), .POST_OUTPUT_WAIT(2)) u_pw (
        .clk(clk), .rst(rst), .data_in_valid(p_v), .data_in(din), .data_in_ready(p_rdy),
        .data_out_valid(p_ov), .data_out(p_od), .data_out_ready(out_rdy), .layer_ap_rst(p_arst),
        .layer_ap_start(p_st), .layer_data_in(p_ldi), .layer_data_out(lo0), .layer_ap_done(1'b0),
        .fifo_count(p_fc), .err_overflow(p_err));

    hls_layer_stream_adapter #(.NUM_IN(1), .IN_W(16), .NUM_OUT(2), .OUT_W(33), .LATENCY(4), .II(1),
        .FIFO_DEPTH(4), .POST_OUTPUT_WAIT(0)) u_rst (
        .clk(clk), .rst(rst), .data_in_valid(r_v), .data_in(din), .data_in_ready(r_rdy),
        .data_out_valid(r_ov), .data_out(r_od), .data_out_ready(out_rdy), .layer_ap_rst(r_arst),
        .layer_ap_start(r_st), .layer_data_in(r_ldi), .layer_data_out(lo4), .layer_ap_done(1'b0),
        .fifo_count(r_fc), .err_overflow(r_err));

    task automatic test_reset();
        rst = 1'b1; out_rdy = 1'b1; seq_done = 1'b0; din = 16'h5a5a;
        {s_v, b_v, i_v, q_v, p_v, r_v} = '1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if ({s_rdy, b_rdy, i_rdy, q_rdy, p_rdy, r_rdy} !== 6'b0)
            $display("FAIL reset_ready: got %b expected 000000", {s_rdy, b_rdy, i_rdy, q_rdy, p_rdy, r_rdy}); else passed++;
        checks++; if ({s_ov, b_ov, i_ov, q_ov, p_ov, r_ov} !== 6'b0)
            $display("FAIL reset_out_valid: got %b expected 000000", {s_ov, b_ov, i_ov, q_ov, p_ov, r_ov}); else passed++;
        checks++; if ({s_st, b_st, i_st, q_st, p_st, r_st} !== 6'b0)
            $display("FAIL reset_start: got %b expected 000000", {s_st, b_st, i_st, q_st, p_st, r_st}); else passed++;
        checks++; if ({s_fc, b_fc, i_fc, q_fc, p_fc, r_fc} !== 18'b0)
            $display("FAIL reset_fifo_count: got %h expected 0", {s_fc, b_fc, i_fc, q_fc, p_fc, r_fc}); else passed++;
        checks++; if ({s_err, b_err, i_err, q_err, p_err, r_err} !== 6'b0)
            $display("FAIL reset_err: got %b expected 000000", {s_err, b_err, i_err, q_err, p_err, r_err}); else passed++;
        checks++; if ({s_arst, b_arst, i_arst, q_arst, p_arst, r_arst} !== 6'b111111)
            $display("FAIL reset_layer_rst: got %b expected 111111", {s_arst, b_arst, i_arst, q_arst, p_arst, r_arst}); else passed++;
        checks++; if ({s_ldi, b_ldi, i_ldi, q_ldi, p_ldi, r_ldi} !== {6{din}})
            $display("FAIL layer_data_in: got %h expected %h", {s_ldi, b_ldi, i_ldi, q_ldi, p_ldi, r_ldi}, {6{din}}); else passed++;
        rst = 1'b0;
        {s_v, b_v, i_v, q_v, p_v, r_v} = '0;
        @(posedge clk); #2;
        checks++; if (s_rdy !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", s_rdy); else passed++;
    endtask

    task automatic test_streaming();
        int first = -1, nout = 0, gaps = 0, notrdy = 0;
        out_rdy = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            s_v = (c < 20); din = 16'(c);
            #1;
            if (c < 20 && s_rdy !== 1'b1) notrdy++;
            if (s_ov) begin
                if (first < 0) first = c;
                checks++; if (s_od !== f(16'(nout)))
                    $display("FAIL stream_data[%0d]: got %h expected %h", nout, s_od, f(16'(nout))); else passed++;
                if (c != first + nout) gaps++;
                nout++;
            end
        end
        s_v = 1'b0;
        checks++; if (notrdy != 0) $display("FAIL stream_ready_drop: got %0d low cycles expected 0", notrdy); else passed++;
        checks++; if (first != 4) $display("FAIL stream_first_latency: got %0d expected 4", first); else passed++;
        checks++; if (nout != 20) $display("FAIL stream_out_count: got %0d expected 20", nout); else passed++;
        checks++; if (gaps != 0) $display("FAIL stream_gaps: got %0d expected 0", gaps); else passed++;
        checks++; if (s_err !== 1'b0) $display("FAIL stream_err: got %b expected 0", s_err); else passed++;
    endtask

    task automatic test_backpressure();
        int fires = 0, n = 0;
        out_rdy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            b_v = 1'b1; din = 16'(100 + fires);
            #1;
            if (b_rdy) fires++;
        end
        @(posedge clk); #1;
        b_v = 1'b0;
        #1;
        checks++; if (fires != 4) $display("FAIL bp_accepted: got %0d expected 4", fires); else passed++;
        checks++; if (b_fc !== 3'd4) $display("FAIL bp_fifo_count: got %0d expected 4", b_fc); else passed++;
        checks++; if (b_rdy !== 1'b0) $display("FAIL bp_ready: got %b expected 0", b_rdy); else passed++;
        checks++; if (b_ov !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", b_ov); else passed++;
        checks++; if (b_err !== 1'b0) $display("FAIL bp_err_full: got %b expected 0", b_err); else passed++;
        out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (b_ov) begin
                checks++; if (b_od !== f(16'(100 + n)))
                    $display("FAIL bp_drain[%0d]: got %h expected %h", n, b_od, f(16'(100 + n))); else passed++;
                n++;
            end
            @(posedge clk); #2;
        end
        checks++; if (n != 4) $display("FAIL bp_drain_count: got %0d expected 4", n); else passed++;
        checks++; if (b_fc !== 3'd0) $display("FAIL bp_drain_empty: got %0d expected 0", b_fc); else passed++;
        checks++; if (b_err !== 1'b0) $display("FAIL bp_err_after: got %b expected 0", b_err); else passed++;
    endtask

    task automatic test_ii();
        int nf = 0, no = 0;
        int fcy [4];
        int ocy [4];
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin fcy[k] = -1; ocy[k] = -1; end
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            i_v = (nf < 4); din = 16'(200 + nf);
            #1;
            if (i_v && i_rdy) begin fcy[nf] = c; nf++; end
            if (i_ov) begin
                checks++; if (i_od !== f(16'(200 + no)))
                    $display("FAIL ii_data[%0d]: got %h expected %h", no, i_od, f(16'(200 + no))); else passed++;
                if (no < 4) ocy[no] = c;
                no++;
            end
        end
        i_v = 1'b0;
        checks++; if (nf != 4) $display("FAIL ii_fire_count: got %0d expected 4", nf); else passed++;
        checks++; if (no != 4) $display("FAIL ii_out_count: got %0d expected 4", no); else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++; if (fcy[k] != 3 * k) $display("FAIL ii_fire_cycle[%0d]: got %0d expected %0d", k, fcy[k], 3 * k); else passed++;
            checks++; if (ocy[k] != 3 * k + 3) $display("FAIL ii_out_cycle[%0d]: got %0d expected %0d", k, ocy[k], 3 * k + 3); else passed++;
        end
    endtask

    task automatic test_sequential();
        int spur = 0, nf = 0, no = 0, last = -100, busy = 0;
        int fcy [3];
        int ocy [3];
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin fcy[k] = -1; ocy[k] = -1; end
        @(posedge clk); #1; seq_done = 1'b1;
        @(posedge clk); #1; seq_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (q_ov !== 1'b0 || q_fc !== 3'd0) spur++;
            @(posedge clk); #1;
        end
        checks++; if (spur != 0) $display("FAIL seq_spurious_done: got %0d bad cycles expected 0", spur); else passed++;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            q_v = (nf < 3); din = 16'(300 + nf);
            seq_done = (nf > 0) && (c == last + 5);
            #1;
            if (nf > 0 && c > last && c <= last + 5 && q_rdy !== 1'b0) busy++;
            if (q_v && q_rdy) begin fcy[nf] = c; last = c; nf++; end
            if (q_ov) begin
                checks++; if (q_od !== f(16'(300 + no)))
                    $display("FAIL seq_data[%0d]: got %h expected %h", no, q_od, f(16'(300 + no))); else passed++;
                if (no < 3) ocy[no] = c;
                no++;
            end
        end
        q_v = 1'b0; seq_done = 1'b0;
        checks++; if (busy != 0) $display("FAIL seq_ready_while_busy: got %0d expected 0", busy); else passed++;
        checks++; if (no != 3) $display("FAIL seq_out_count: got %0d expected 3", no); else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++; if (fcy[k] != 6 * k) $display("FAIL seq_fire_cycle[%0d]: got %0d expected %0d", k, fcy[k], 6 * k); else passed++;
            checks++; if (ocy[k] != 6 * k + 6) $display("FAIL seq_out_cycle[%0d]: got %0d expected %0d", k, ocy[k], 6 * k + 6); else passed++;
        end
    endtask

    task automatic test_post_wait();
        logic [3:0] rp;
        int nf = 0, no = 0, mask = 0;
        out_rdy = 1'b1;
        @(posedge clk); #1;
        p_v = 1'b1; din = 16'd400;
        #1;
        checks++; if (p_rdy !== 1'b1) $display("FAIL pw_initial_ready: got %b expected 1", p_rdy); else passed++;
        @(posedge clk); #1;
        p_v = 1'b0;
        #1;
        checks++; if (p_ov !== 1'b1 || p_od !== f(16'd400))
            $display("FAIL pw_single_out: got %b/%h expected 1/%h", p_ov, p_od, f(16'd400)); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            rp[k] = p_rdy;
        end
        checks++; if (rp !== 4'b1100) $display("FAIL pw_ready_gap: got %b expected 1100", rp); else passed++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            p_v = (nf < 4); din = 16'(410 + nf);
            #1;
            if (p_v && p_rdy) begin mask |= (1 << c); nf++; end
            if (p_ov) begin
                checks++; if (p_od !== f(16'(410 + no)))
                    $display("FAIL pw_data[%0d]: got %h expected %h", no, p_od, f(16'(410 + no))); else passed++;
                no++;
            end
        end
        p_v = 1'b0;
        checks++; if (mask != 32'h63) $display("FAIL pw_fire_pattern: got %0h expected 63", mask); else passed++;
        checks++; if (no != 4) $display("FAIL pw_out_count: got %0d expected 4", no); else passed++;
    endtask

    task automatic test_reset_midflight();
        int nf = 0, stale = 0;
        out_rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            r_v = 1'b1; din = 16'(500 + c);
            #1;
            if (r_rdy) nf++;
        end
        @(posedge clk); #1;
        r_v = 1'b0;
        @(posedge clk); #2;
        checks++; if (nf != 4) $display("FAIL rst_pre_fires: got %0d expected 4", nf); else passed++;
        checks++; if (r_fc !== 3'd1) $display("FAIL rst_pre_fifo_count: got %0d expected 1", r_fc); else passed++;
        checks++; if (r_rdy !== 1'b0) $display("FAIL rst_pre_ready: got %b expected 0", r_rdy); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (r_fc !== 3'd0) $display("FAIL rst_during_fifo_count: got %0d expected 0", r_fc); else passed++;
        checks++; if (r_ov !== 1'b0) $display("FAIL rst_during_out_valid: got %b expected 0", r_ov); else passed++;
        checks++; if (r_rdy !== 1'b0) $display("FAIL rst_during_ready: got %b expected 0", r_rdy); else passed++;
        @(posedge clk); #1;
        rst = 1'b0; out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (r_ov !== 1'b0 || r_fc !== 3'd0) stale++;
            @(posedge clk); #1;
        end
        #1;
        checks++; if (stale != 0) $display("FAIL rst_stale_output: got %0d bad cycles expected 0", stale); else passed++;
        checks++; if (r_err !== 1'b0) $display("FAIL rst_err: got %b expected 0", r_err); else passed++;
        checks++; if (r_rdy !== 1'b1) $display("FAIL rst_post_ready: got %b expected 1", r_rdy); else passed++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_ii();
        test_sequential();
        test_post_wait();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, checks);
        $fatal(1);
    end

endmodule
